// File: rtl/enemy_pkg.sv
// Shared types for the enemy hit path: the queued hit event and the helper
// that picks which shot is credited when several shots overlap one enemy.
package enemy_pkg;

  localparam int ENEMY_ID_W = 4;
  localparam int SHOT_COUNT = 3;
  localparam int SHOT_IDX_W = 2;

  typedef struct packed {
    logic [ENEMY_ID_W-1:0] id;
    logic [SHOT_IDX_W-1:0] shot;
  } hit_event_t;

  // Lowest-numbered shot wins when several shots hit the same pixel.
  function automatic logic [SHOT_IDX_W-1:0] lowestShot(input logic [SHOT_COUNT-1:0] shots);
    logic [SHOT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = SHOT_COUNT - 1; i >= 0; i--) begin
      if (shots[i]) idx = SHOT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/enemy_hitFifo.sv
// First-word-fall-through queue of hit events. A push while full is taken
// only when a pop frees a slot in the same cycle; a pop while empty is ignored.
module enemy_hitFifo
  import enemy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       push,
  input  hit_event_t pushData,
  input  logic       pop,
  output hit_event_t headData,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  hit_event_t       mem [DEPTH];
  logic             doPop;
  logic             doPush;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are never observed
  // because the head is forced to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign headData = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/enemy_hitdispatcher.sv
// Enemy hit dispatcher: per-enemy once-per-frame hit/border strobes, hit-event
// queue and player hit latch. Optional score counter under ENEMY_HIT_SCORE_EN.
module enemy_hitdispatcher
  import enemy_pkg::*;
#(
  parameter int AMOUNT_OF_ENEMIES = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int SCORE_PER_HIT     = 10
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  pause,
  input  logic                  enemyDrawReq,
  input  logic                  headsUpDrawReq,
  input  logic [ENEMY_ID_W-1:0] drawingRequestorId,
  input  logic [SHOT_COUNT-1:0] shotDrawReq,
  input  logic                  borderDrawReq,
  input  logic                  playerDrawReq,
  output logic                  changeDir,
  output logic [SHOT_COUNT-1:0] shotCollision,
  output logic                  playerHit,
  output logic                  eventValid,
  output logic [ENEMY_ID_W-1:0] eventId,
  output logic [SHOT_IDX_W-1:0] eventShot,
  input  logic                  eventReady,
  output logic                  overflow
`ifdef ENEMY_HIT_SCORE_EN
  ,
  output logic [15:0]           score
`endif
);

  if (AMOUNT_OF_ENEMIES < 1 || AMOUNT_OF_ENEMIES > 16) begin : gBadAmount
    $error("AMOUNT_OF_ENEMIES must be in 1..16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (SCORE_PER_HIT < 0 || SCORE_PER_HIT > 65535) begin : gBadScore
    $error("SCORE_PER_HIT must fit in 16 bits");
  end

  logic [AMOUNT_OF_ENEMIES-1:0] hitFlag;
  logic [AMOUNT_OF_ENEMIES-1:0] dirFlag;
  logic [AMOUNT_OF_ENEMIES-1:0] idMatch;
  logic [AMOUNT_OF_ENEMIES-1:0] frameKeep;
  logic                         curHit;
  logic                         curDir;
  logic                         pixelValid;
  logic                         hitSet;
  logic                         playerFlag;
  logic                         playerLatched;
  logic                         playerSet;
  hit_event_t                   pushEvent;
  hit_event_t                   headEvent;
  logic                         fifoFull;
  logic                         fifoEmpty;
  logic                         popFires;
  logic                         pushDropped;

  // Ids at or above AMOUNT_OF_ENEMIES match nothing, which makes the pixel invalid.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    idMatch = '0;
    curHit  = 1'b0;
    curDir  = 1'b0;
    for (int i = 0; i < AMOUNT_OF_ENEMIES; i++) begin
      if (drawingRequestorId == ENEMY_ID_W'(i)) begin
        idMatch[i] = 1'b1;
        curHit     = hitFlag[i];
        curDir     = dirFlag[i];
      end
    end
  end

  assign pixelValid    = (|idMatch) & ~pause;
  assign shotCollision = shotDrawReq & {SHOT_COUNT{enemyDrawReq & ~curHit & pixelValid}};
  assign changeDir     = enemyDrawReq & borderDrawReq & ~curDir & pixelValid;
  assign hitSet        = |shotCollision;
  assign playerSet     = headsUpDrawReq & playerDrawReq & ~pause & ~playerFlag;
  assign frameKeep     = {AMOUNT_OF_ENEMIES{~startOfFrame}};

  assign pushEvent.id   = drawingRequestorId;
  assign pushEvent.shot = lowestShot(shotCollision);

  assign popFires    = eventReady & ~fifoEmpty;
  assign pushDropped = hitSet & fifoFull & ~popFires;

  // Clear-then-set ordering lets an event coinciding with startOfFrame count
  // for the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitFlag       <= '0;
      dirFlag       <= '0;
      playerFlag    <= 1'b0;
      playerLatched <= 1'b0;
      playerHit     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      hitFlag       <= (hitFlag & frameKeep) | (idMatch & {AMOUNT_OF_ENEMIES{hitSet}});
      dirFlag       <= (dirFlag & frameKeep) | (idMatch & {AMOUNT_OF_ENEMIES{changeDir}});
      playerFlag    <= (playerFlag & ~startOfFrame) | playerSet;
      playerLatched <= (playerLatched & ~startOfFrame) | playerSet;
      playerHit     <= startOfFrame & playerLatched;
      if (pushDropped) overflow <= 1'b1;
    end
  end

  enemy_hitFifo #(
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .resetN   (resetN),
    .push     (hitSet),
    .pushData (pushEvent),
    .pop      (eventReady),
    .headData (headEvent),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign eventValid = ~fifoEmpty;
  assign eventId    = headEvent.id;
  assign eventShot  = headEvent.shot;

`ifdef ENEMY_HIT_SCORE_EN
  logic        pushAccepted;
  logic [16:0] scoreSum;

  assign pushAccepted = hitSet & (~fifoFull | popFires);
  assign scoreSum     = {1'b0, score} + 17'(SCORE_PER_HIT);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score <= '0;
    end else if (pushAccepted) begin
      score <= scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_enemy_hitdispatcher.sv
// Self-checking bench for enemy_hitdispatcher: a frame/queue model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_enemy_hitdispatcher;
  import enemy_pkg::*;

  localparam int N_EN  = 6;
  localparam int DEPTH = 4;
  localparam int SPH   = 10;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       pause = 1'b0;
  logic       enemyDrawReq = 1'b0;
  logic       headsUpDrawReq = 1'b0;
  logic [3:0] drawingRequestorId = 4'd0;
  logic [2:0] shotDrawReq = 3'b000;
  logic       borderDrawReq = 1'b0;
  logic       playerDrawReq = 1'b0;
  logic       eventReady = 1'b0;
  logic       changeDir;
  logic [2:0] shotCollision;
  logic       playerHit;
  logic       eventValid;
  logic [3:0] eventId;
  logic [1:0] eventShot;
  logic       overflow;
`ifdef ENEMY_HIT_SCORE_EN
  logic [15:0] score;
`endif

  enemy_hitdispatcher #(
    .AMOUNT_OF_ENEMIES(N_EN),
    .FIFO_DEPTH       (DEPTH),
    .SCORE_PER_HIT    (SPH)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .pause             (pause),
    .enemyDrawReq      (enemyDrawReq),
    .headsUpDrawReq    (headsUpDrawReq),
    .drawingRequestorId(drawingRequestorId),
    .shotDrawReq       (shotDrawReq),
    .borderDrawReq     (borderDrawReq),
    .playerDrawReq     (playerDrawReq),
    .changeDir         (changeDir),
    .shotCollision     (shotCollision),
    .playerHit         (playerHit),
    .eventValid        (eventValid),
    .eventId           (eventId),
    .eventShot         (eventShot),
    .eventReady        (eventReady),
    .overflow          (overflow)
`ifdef ENEMY_HIT_SCORE_EN
    ,
    .score             (score)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int dirPulses = 0;
  int playerPulses = 0;

  // Model state: which enemies already scored/turned this frame, the event list.
  bit         mHit [16];
  bit         mDir [16];
  bit         mPFlag, mPLatch, mPHit, mOvf;
  hit_event_t q[$];
  int         mScore;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pixOk();
    return (int'(drawingRequestorId) < N_EN) && !pause;
  endfunction

  function automatic logic [2:0] expShot();
    if (enemyDrawReq && pixOk() && !mHit[drawingRequestorId]) return shotDrawReq;
    return 3'b000;
  endfunction

  function automatic logic expDir();
    return enemyDrawReq && borderDrawReq && pixOk() && !mDir[drawingRequestorId];
  endfunction

  always @(posedge clk or negedge resetN) begin : modelProc
    logic [2:0] s;
    logic       d;
    bit         pset;
    bit         pop;
    int         sz;
    hit_event_t ev;
    if (!resetN) begin
      for (int i = 0; i < 16; i++) begin
        mHit[i] = 1'b0;
        mDir[i] = 1'b0;
      end
      mPFlag = 0; mPLatch = 0; mPHit = 0; mOvf = 0; mScore = 0;
      q.delete();
    end else begin
      s    = expShot();
      d    = expDir();
      pset = headsUpDrawReq && playerDrawReq && !pause && !mPFlag;
      sz   = q.size();
      pop  = (sz > 0) && eventReady;
      if (pop) void'(q.pop_front());
      if (s != 3'b000) begin
        ev.id   = drawingRequestorId;
        ev.shot = s[0] ? 2'd0 : (s[1] ? 2'd1 : 2'd2);
        if (sz < DEPTH || pop) begin
          q.push_back(ev);
          mScore = (mScore + SPH > 65535) ? 65535 : mScore + SPH;
        end else begin
          mOvf = 1;
        end
      end
      mPHit = startOfFrame && mPLatch;
      if (startOfFrame) begin
        for (int i = 0; i < 16; i++) begin
          mHit[i] = 1'b0;
          mDir[i] = 1'b0;
        end
        mPFlag = 0;
        mPLatch = 0;
      end
      if (s != 3'b000) mHit[drawingRequestorId] = 1'b1;
      if (d) mDir[drawingRequestorId] = 1'b1;
      if (pset) begin
        mPFlag = 1;
        mPLatch = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (resetN) begin
      check("shotCollision", int'(shotCollision), int'(expShot()));
      check("changeDir", int'(changeDir), int'(expDir()));
      check("playerHit", int'(playerHit), int'(mPHit));
      check("eventValid", int'(eventValid), (q.size() > 0) ? 1 : 0);
      check("eventId", int'(eventId), (q.size() > 0) ? int'(q[0].id) : 0);
      check("eventShot", int'(eventShot), (q.size() > 0) ? int'(q[0].shot) : 0);
      check("overflow", int'(overflow), int'(mOvf));
`ifdef ENEMY_HIT_SCORE_EN
      check("score", int'(score), mScore);
`endif
      if (changeDir) dirPulses++;
      if (playerHit) playerPulses++;
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic setPix(input logic [3:0] id, input logic en, input logic [2:0] sh, input logic bd);
    drawingRequestorId = id;
    enemyDrawReq       = en;
    shotDrawReq        = sh;
    borderDrawReq      = bd;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    adv();
    startOfFrame = 1'b0;
  endtask

  int d0, p0;
  int drainShotsD [4] = '{0, 0, 0, 2};
  int drainShotsC [4] = '{0, 1, 2, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) adv();
    @(negedge clk);
    check("rst eventValid", int'(eventValid), 0);
    check("rst eventId", int'(eventId), 0);
    check("rst overflow", int'(overflow), 0);
    check("rst playerHit", int'(playerHit), 0);
    adv();
    resetN = 1'b1;
    adv();

    // One enemy covered by shots 1 and 2 for three pixels.
    setPix(4'd1, 1'b1, 3'b110, 1'b0);
    @(negedge clk);
    check("A p1 shotCollision", int'(shotCollision), 6);
    check("A p1 eventValid", int'(eventValid), 0);
    adv();
    @(negedge clk);
    check("A p2 shotCollision", int'(shotCollision), 0);
    check("A p2 eventValid", int'(eventValid), 1);
    check("A p2 eventId", int'(eventId), 1);
    check("A p2 eventShot", int'(eventShot), 1);
    adv();
    @(negedge clk);
    check("A p3 shotCollision", int'(shotCollision), 0);
    adv();
    setPix(4'd0, 1'b0, 3'b000, 1'b0);
    eventReady = 1'b1;
    adv();
    eventReady = 1'b0;
    @(negedge clk);
    check("A popped eventValid", int'(eventValid), 0);
    adv();

    // Border twice in one frame, once in the next.
    d0 = dirPulses;
    setPix(4'd0, 1'b1, 3'b000, 1'b1);
    adv();
    adv();
    setPix(4'd0, 1'b0, 3'b000, 1'b0);
    frame();
    setPix(4'd0, 1'b1, 3'b000, 1'b1);
    adv();
    setPix(4'd0, 1'b0, 3'b000, 1'b0);
    adv();
    @(negedge clk);
    check("B changeDir pulses", dirPulses - d0, 2);
    adv();

    // Fill the queue, then push and pop together while full.
    frame();
    for (int k = 0; k < 4; k++) begin
      setPix(4'(k), 1'b1, 3'b001, 1'b0);
      adv();
    end
    setPix(4'd4, 1'b1, 3'b100, 1'b0);
    eventReady = 1'b1;
    @(negedge clk);
    check("D full head", int'(eventId), 0);
    check("D full shotCollision", int'(shotCollision), 4);
    adv();
    setPix(4'd0, 1'b0, 3'b000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("D drain id", int'(eventId), k + 1);
      check("D drain shot", int'(eventShot), drainShotsD[k]);
      adv();
    end
    eventReady = 1'b0;
    @(negedge clk);
    check("D drained eventValid", int'(eventValid), 0);
    check("D overflow", int'(overflow), 0);
    adv();

    // Player overlapping the heads-up zone for two pixels mid-frame.
    p0 = playerPulses;
    headsUpDrawReq = 1'b1;
    playerDrawReq  = 1'b1;
    adv();
    adv();
    headsUpDrawReq = 1'b0;
    playerDrawReq  = 1'b0;
    @(negedge clk);
    check("E before frame", int'(playerHit), 0);
    adv();
    startOfFrame = 1'b1;
    @(negedge clk);
    check("E sof cycle", int'(playerHit), 0);
    adv();
    startOfFrame = 1'b0;
    @(negedge clk);
    check("E pulse", int'(playerHit), 1);
    adv();
    @(negedge clk);
    check("E pulse end", int'(playerHit), 0);
    adv();
    frame();
    adv();
    adv();
    @(negedge clk);
    check("E pulse count", playerPulses - p0, 1);
    adv();

    // Pause and out-of-range ids gate everything.
    pause = 1'b1;
    setPix(4'd2, 1'b1, 3'b001, 1'b1);
    @(negedge clk);
    check("F pause shot", int'(shotCollision), 0);
    check("F pause dir", int'(changeDir), 0);
    adv();
    pause = 1'b0;
    @(negedge clk);
    check("F pause no event", int'(eventValid), 0);
    check("F unpaused shot", int'(shotCollision), 1);
    check("F unpaused dir", int'(changeDir), 1);
    adv();
    setPix(4'd15, 1'b1, 3'b111, 1'b1);
    @(negedge clk);
    check("F id15 shot", int'(shotCollision), 0);
    check("F id15 dir", int'(changeDir), 0);
    adv();
    setPix(4'd6, 1'b1, 3'b111, 1'b1);
    @(negedge clk);
    check("F id6 shot", int'(shotCollision), 0);
    adv();
    setPix(4'd5, 1'b1, 3'b010, 1'b1);
    @(negedge clk);
    check("F id5 shot", int'(shotCollision), 2);
    adv();
    setPix(4'd0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    check("F head id", int'(eventId), 2);
    eventReady = 1'b1;
    adv();
    adv();
    eventReady = 1'b0;
    @(negedge clk);
    check("F drained", int'(eventValid), 0);
    adv();

    // Five hits on distinct enemies, the first coinciding with startOfFrame.
    startOfFrame = 1'b1;
    setPix(4'd0, 1'b1, 3'b001, 1'b0);
    adv();
    startOfFrame = 1'b0;
    setPix(4'd1, 1'b1, 3'b010, 1'b0);
    adv();
    setPix(4'd2, 1'b1, 3'b100, 1'b0);
    adv();
    setPix(4'd3, 1'b1, 3'b011, 1'b0);
    adv();
    setPix(4'd4, 1'b1, 3'b111, 1'b0);
    adv();
    setPix(4'd0, 1'b1, 3'b001, 1'b0);
    @(negedge clk);
    check("C set wins", int'(shotCollision), 0);
    check("C overflow", int'(overflow), 1);
    check("C head id", int'(eventId), 0);
`ifdef ENEMY_HIT_SCORE_EN
    check("C score", int'(score), 120);
`endif
    adv();
    setPix(4'd0, 1'b0, 3'b000, 1'b0);
    eventReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("C drain id", int'(eventId), k);
      check("C drain shot", int'(eventShot), drainShotsC[k]);
      adv();
    end
    eventReady = 1'b0;
    @(negedge clk);
    check("C drained", int'(eventValid), 0);
    check("C overflow sticky", int'(overflow), 1);
    adv();

    // Reset with events queued and a player hit pending.
    frame();
    setPix(4'd0, 1'b1, 3'b001, 1'b0);
    headsUpDrawReq = 1'b1;
    playerDrawReq  = 1'b1;
    adv();
    setPix(4'd1, 1'b1, 3'b001, 1'b0);
    headsUpDrawReq = 1'b0;
    playerDrawReq  = 1'b0;
    adv();
    setPix(4'd0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    check("R queued", int'(eventValid), 1);
    adv();
    resetN = 1'b0;
    #1;
    check("R async eventValid", int'(eventValid), 0);
    check("R async overflow", int'(overflow), 0);
    adv();
    resetN = 1'b1;
    frame();
    @(negedge clk);
    check("R no playerHit", int'(playerHit), 0);
    check("R empty", int'(eventValid), 0);
    adv();
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
